// File: rtl/phase_sampler.sv
// phase_sampler: synchronises N async oscillator bits, counts per spin the
// clk cycles that differ from the reference spin (N-1) over a start-triggered
// window, and resolves each count to a binary spin value.
// Optional build macro: PHASE_SETTLE_EN adds a SETTLE_CYCLES settle phase
// between start and counting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, no result
// ST_SETTLE| settle delay after start, no counting (PHASE_SETTLE_EN only)
// ST_COUNT | accumulating mismatches, WINDOW edges
// ST_DONE  | counts and spins held, done=1 until next accepted start
module phase_sampler #(
    parameter int N             = 8,
    parameter int WINDOW        = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 axi_rst,
    input  logic [N-1:0]         right_col,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         spins,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [31:0]          rd_data
);

    localparam int CW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef PHASE_SETTLE_EN
        ST_SETTLE = 2'd1,
`endif
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [CW-1:0]                 r_cnt [N];
    logic [CW-1:0]                 w_cnt_next [N-1];
    logic [CW-1:0]                 r_win;
    logic [N-1:0]                  r_spins;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_ref;

`ifdef PHASE_SETTLE_EN
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    logic [SW-1:0]                 r_settle;
`endif

    assign w_ref    = r_sync[SYNC_STAGES-1][N-1];
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_win == CW'(WINDOW - 1));

    // Synchroniser chain per right_col bit.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= right_col;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef PHASE_SETTLE_EN
                    w_next = ST_SETTLE;
`else
                    w_next = ST_COUNT;
`endif
                end
            end
`ifdef PHASE_SETTLE_EN
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_next = ST_COUNT;
                end
            end
`endif
            ST_COUNT: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; spins come from their own register.
    always_comb begin
        busy = (r_state == ST_COUNT);
`ifdef PHASE_SETTLE_EN
        busy = busy || (r_state == ST_SETTLE);
`endif
        done  = (r_state == ST_DONE);
        spins = r_spins;
    end

    // Count including the current sample; the reference spin is never counted.
    always_comb begin
        for (int i = 0; i < N - 1; i++) begin
            w_cnt_next[i] = r_cnt[i] + CW'(r_sync[SYNC_STAGES-1][i] ^ w_ref);
        end
    end

    // Window, mismatch counters and spin resolution.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            r_win   <= '0;
            r_spins <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
`ifdef PHASE_SETTLE_EN
            r_settle <= '0;
`endif
        end else if (w_accept) begin
            r_win <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
`ifdef PHASE_SETTLE_EN
            r_settle <= SW'(SETTLE_CYCLES - 1);
`endif
        end else begin
`ifdef PHASE_SETTLE_EN
            if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
                r_settle <= r_settle - 1'b1;
            end
`endif
            if (r_state == ST_COUNT) begin
                r_win <= r_win + 1'b1;
                for (int i = 0; i < N - 1; i++) begin
                    r_cnt[i] <= w_cnt_next[i];
                end
                if (w_last) begin
                    for (int i = 0; i < N - 1; i++) begin
                        r_spins[i] <= (w_cnt_next[i] > CW'(WINDOW / 2));
                    end
                    r_spins[N-1] <= 1'b0;
                end
            end
        end
    end

    // Read path: zero-extended live count, out-of-range addresses read 0.
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < 32'(N)) begin
            rd_data = 32'(r_cnt[rd_addr]);
        end
    end

endmodule

// File: tb/tb_phase_sampler.sv
// Bench for phase_sampler: history-based reference of mismatch counts.
module tb_phase_sampler;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
`ifdef PHASE_SETTLE_EN
    localparam int S_EFF = SETTLE;
`else
    localparam int S_EFF = 0;
`endif
    localparam int HMAX = 8192;

    logic         clk = 1'b0;
    logic         axi_rst;
    logic [N-1:0] right_col;
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] spins;
    logic [1:0]   rd_addr;
    logic [31:0]  rd_data;

    int vectors = 0;
    int errors  = 0;
    int edge_n  = 0;
    int mode    = 0;
    logic [N-1:0] hist [HMAX];

    always #5 clk = ~clk;

    phase_sampler #(
        .N(N), .WINDOW(W), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .axi_rst(axi_rst), .right_col(right_col), .start(start),
        .busy(busy), .done(done), .spins(spins), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Record the input value seen at every rising edge, indexed by edge number.
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (edge_n + 1 < HMAX) hist[edge_n + 1] <= right_col;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update right_col per mode.
    task automatic step();
        @(negedge clk);
        case (mode)
            1: right_col = N'($urandom);
            2: right_col[0] = ~right_col[0];
            default: ;
        endcase
    endtask

    // Mismatches of spin i over counting edges k+S+1 .. min(t_end, k+S+W);
    // the value used at edge t entered the pin SYNC edges earlier.
    function automatic int model_cnt(input int i, input int k, input int t_end);
        int c = 0;
        for (int t = k + S_EFF + 1; t <= t_end && t <= k + S_EFF + W; t++) begin
            if (hist[t - SYNC][i] != hist[t - SYNC][N-1]) c++;
        end
        return c;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_spins"}, 32'(spins), 0);
        for (int a = 0; a < N; a++) begin
            rd_addr = 2'(a);
            #1;
            check($sformatf("%s_rd%0d", tag, a), rd_data, 0);
        end
    endtask

    task automatic measure(input string tag, input int restart_at);
        int k;
        int got;
        int m;
        logic [N-1:0] exp_spins;
        for (int h = 0; h < 3; h++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        k = edge_n;
        got = 0;
        for (int c = 0; c < W + S_EFF + 8; c++) begin
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            check({tag, "_busy"}, 32'(busy), 1);
            rd_addr = 2'(c % N);
            #1;
            check({tag, "_live"}, rd_data, 32'(model_cnt(c % N, k, edge_n)));
            start = (c == restart_at);
            step();
        end
        start = 1'b0;
        check({tag, "_latency"}, got ? 32'(edge_n - k) : 32'hFFFF_FFFF, 32'(W + S_EFF));
        check({tag, "_busy_end"}, 32'(busy), 0);
        exp_spins = '0;
        for (int a = 0; a < N; a++) begin
            m = model_cnt(a, k, k + S_EFF + W);
            if (a < N - 1 && m > W / 2) exp_spins[a] = 1'b1;
            rd_addr = 2'(a);
            #1;
            check($sformatf("%s_cnt%0d", tag, a), rd_data, 32'(m));
        end
        check({tag, "_spins"}, 32'(spins), 32'(exp_spins));
        for (int h = 0; h < 3; h++) step();
        rd_addr = 2'd0;
        #1;
        check({tag, "_hold_done"}, 32'(done), 1);
        check({tag, "_hold_cnt0"}, rd_data, 32'(model_cnt(0, k, k + S_EFF + W)));
        check({tag, "_hold_spins"}, 32'(spins), 32'(exp_spins));
    endtask

    initial begin
        axi_rst   = 1'b1;
        start     = 1'b0;
        right_col = '0;
        rd_addr   = '0;
        mode      = 0;
        step();
        step();
        axi_rst = 1'b0;
        step();
        check_reset_state("reset");

        right_col = 4'b0000;
        measure("zero", -1);

        right_col = 4'b0011;
        measure("pair", -1);

        right_col = 4'b0001;
        measure("single", -1);

        right_col = 4'b0000;
        mode = 2;
        measure("tie", -1);
        mode = 0;

        right_col = 4'b0010;
        measure("restart_ignored", S_EFF + 5);

        // Reset in the middle of a window discards the partial result.
        right_col = 4'b0011;
        for (int h = 0; h < 3; h++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int h = 0; h < S_EFF + 6; h++) step();
        axi_rst = 1'b1;
        step();
        axi_rst = 1'b0;
        check_reset_state("midrst");

        mode = 1;
        for (int r = 0; r < 6; r++) begin
            measure($sformatf("rand%0d", r), (r == 2) ? S_EFF + 3 : -1);
        end
        mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
